// File: rtl/fifo_ms_pkg.sv
// Shared helpers for the multi-stream FIFO: width helpers and the
// round-robin grant search.
package fifo_ms_pkg;

    function automatic int tag_w(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // First set bit after `last`, cyclically; returns `last` if none.
    function automatic int rr_next(
        input logic [31:0] elig,
        input int          last,
        input int          flux
    );
        int   g;
        logic hit;
        g   = last;
        hit = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (!hit && k <= flux) begin
                int idx;
                idx = (last + k) % flux;
                if (elig[idx[4:0]]) begin
                    g   = idx;
                    hit = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/fifo_ms_rr_if.sv
// Tagged write port, per-stream status and shared return bus of the
// multi-stream FIFO.
interface fifo_ms_rr_if
    import fifo_ms_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int FLUX       = 2
) ();
    localparam int TW = tag_w(FLUX);
    localparam int CW = cnt_w(DEPTH);

    logic [DATA_WIDTH+TW-1:0] din;
    logic                     write;
    logic [FLUX-1:0]          full;
    logic [FLUX-1:0]          almost_full;
    logic [FLUX*CW-1:0]       count;
    logic [FLUX-1:0]          read;
    logic [FLUX-1:0]          empty;
    logic [DATA_WIDTH+TW-1:0] dout;
    logic                     dout_valid;
    logic                     err_clr;
    logic [FLUX-1:0]          overflow;
    logic [FLUX-1:0]          underflow;
    logic                     bad_tag;

    modport master (
        output din, write, read, err_clr,
        input  full, almost_full, count, empty,
        input  dout, dout_valid, overflow, underflow, bad_tag
    );

    modport slave (
        input  din, write, read, err_clr,
        output full, almost_full, count, empty,
        output dout, dout_valid, overflow, underflow, bad_tag
    );
endinterface

// File: rtl/fifo_ms_chan.sv
// One circular buffer; the parent only pushes when not full and only
// pops when not empty.
module fifo_ms_chan
    import fifo_ms_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    localparam int CW      = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign rdata       = mem_q[rptr_q];
    assign count       = cnt_q;
    assign full        = (cnt_q == CW'(DEPTH));
    assign empty       = (cnt_q == '0);
    assign almost_full = (cnt_q >= CW'(AF_LEVEL));
endmodule

// File: rtl/fifo_ms_rr.sv
// Multi-stream FIFO: tag demux into FLUX buffers, round-robin read
// arbitration onto one registered tagged bus, sticky error flags.
module fifo_ms_rr
    import fifo_ms_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int FLUX       = 2,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input logic         clk,
    input logic         rst,
    fifo_ms_rr_if.slave bus
);
    localparam int TW = tag_w(FLUX);
    localparam int CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [TW-1:0]         tag;
        logic [DATA_WIDTH-1:0] payload;
    } ent_t;

    ent_t                  wr;
    ent_t                  dout_q, dout_d;
    logic                  dv_q, dv_d;
    logic [TW-1:0]         last_q, last_d;
    logic [TW-1:0]         gnt;
    logic                  any;
    logic                  tag_ok;
    logic [31:0]           elig32;
    logic [FLUX-1:0]       push, pop, elig;
    logic [FLUX-1:0]       full, empty, af;
    logic [FLUX-1:0]       ovf_new, udf_new;
    logic [FLUX-1:0]       ovf_q, ovf_d, udf_q, udf_d;
    logic                  bad_q, bad_d;
    logic [DATA_WIDTH-1:0] rdata [FLUX];
    logic [CW-1:0]         cnt [FLUX];
    logic [FLUX*CW-1:0]    cnt_flat;

    assign wr     = bus.din;
    assign tag_ok = ({1'b0, wr.tag} < (TW+1)'(FLUX));

    for (genvar i = 0; i < FLUX; i++) begin : g_chan
        fifo_ms_chan #(
            .WIDTH   (DATA_WIDTH),
            .DEPTH   (DEPTH),
            .AF_LEVEL(AF_LEVEL)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .push       (push[i]),
            .pop        (pop[i]),
            .wdata      (wr.payload),
            .rdata      (rdata[i]),
            .count      (cnt[i]),
            .full       (full[i]),
            .empty      (empty[i]),
            .almost_full(af[i])
        );
    end

    always_comb begin
        elig   = bus.read & ~empty;
        any    = |elig;
        elig32 = '0;
        elig32[FLUX-1:0] = elig;
        gnt    = TW'(rr_next(elig32, int'(last_q), FLUX));
        push     = '0;
        pop      = '0;
        ovf_new  = '0;
        cnt_flat = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (bus.write && tag_ok && wr.tag == TW'(i)) begin
                push[i]    = !full[i];
                ovf_new[i] = full[i];
            end
            pop[i] = any && (gnt == TW'(i));
            cnt_flat[i*CW +: CW] = cnt[i];
        end
        udf_new = bus.read & empty;
        // dout keeps its last value on idle cycles.
        dout_d.tag     = any ? gnt : dout_q.tag;
        dout_d.payload = any ? rdata[gnt] : dout_q.payload;
        dv_d    = any;
        last_d  = any ? gnt : last_q;
        ovf_d   = (bus.err_clr ? '0 : ovf_q) | ovf_new;
        udf_d   = (bus.err_clr ? '0 : udf_q) | udf_new;
        bad_d   = (bus.err_clr ? 1'b0 : bad_q) | (bus.write && !tag_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
            last_q <= TW'(FLUX - 1);
            ovf_q  <= '0;
            udf_q  <= '0;
            bad_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            dv_q   <= dv_d;
            last_q <= last_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            bad_q  <= bad_d;
        end
    end

    assign bus.full        = full;
    assign bus.almost_full = af;
    assign bus.empty       = empty;
    assign bus.count       = cnt_flat;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dv_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;
    assign bus.bad_tag     = bad_q;
endmodule

// File: tb/tb_fifo_ms_rr.sv
// Randomized and directed checks of fifo_ms_rr (FLUX=3, DEPTH=4)
// against a queue-based reference model.
module tb_fifo_ms_rr;
    localparam int DW = 8;
    localparam int FL = 3;
    localparam int DP = 4;
    localparam int AF = 3;

    logic clk;
    logic rst;
    int   compares;
    int   fails;

    fifo_ms_rr_if #(.DATA_WIDTH(DW), .DEPTH(DP), .FLUX(FL)) bus ();

    fifo_ms_rr #(
        .DATA_WIDTH(DW),
        .DEPTH     (DP),
        .FLUX      (FL),
        .AF_LEVEL  (AF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mq [FL][$];
    int         mlast;
    logic [9:0] m_dout;
    logic       m_dv;
    logic [2:0] m_ovf, m_udf;
    logic       m_bad;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < FL; i++) mq[i].delete();
        mlast  = FL - 1;
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = '0;
        m_udf  = '0;
        m_bad  = 1'b0;
    endtask

    task automatic check_model();
        logic [2:0] e_emp, e_full, e_af;
        logic [8:0] e_cnt;
        e_emp = '0; e_full = '0; e_af = '0; e_cnt = '0;
        for (int i = 0; i < FL; i++) begin
            int n;
            n = mq[i].size();
            e_emp[i]  = (n == 0);
            e_full[i] = (n == DP);
            e_af[i]   = (n >= AF);
            e_cnt     = e_cnt | (9'(n) << (i * 3));
        end
        chk("empty", 32'(bus.empty), 32'(e_emp));
        chk("full", 32'(bus.full), 32'(e_full));
        chk("almost_full", 32'(bus.almost_full), 32'(e_af));
        chk("count", 32'(bus.count), 32'(e_cnt));
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
        chk("dout", 32'(bus.dout), 32'(m_dout));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_udf));
        chk("bad_tag", 32'(bus.bad_tag), 32'(m_bad));
    endtask

    // Apply one clock edge's worth of spec rules to the model.
    task automatic model_step();
        logic [9:0] d;
        int         tag, g;
        bit         acc, g_any;
        logic [2:0] ovf_n, udf_n;
        logic       bad_n;
        d     = bus.din;
        tag   = int'(d[9:8]);
        ovf_n = '0; udf_n = '0; bad_n = 1'b0;
        acc   = 1'b0;
        if (bus.write) begin
            if (tag >= FL) bad_n = 1'b1;
            else if (mq[tag].size() == DP) ovf_n[tag] = 1'b1;
            else acc = 1'b1;
        end
        for (int i = 0; i < FL; i++)
            if (bus.read[i] && mq[i].size() == 0) udf_n[i] = 1'b1;
        g_any = 1'b0;
        g     = 0;
        for (int k = 1; k <= FL; k++) begin
            int idx;
            idx = (mlast + k) % FL;
            if (!g_any && bus.read[idx] && mq[idx].size() > 0) begin
                g     = idx;
                g_any = 1'b1;
            end
        end
        if (g_any) begin
            m_dout = {g[1:0], mq[g][0]};
            void'(mq[g].pop_front());
            mlast = g;
        end
        m_dv = g_any;
        if (acc) mq[tag].push_back(d[7:0]);
        m_ovf = (bus.err_clr ? 3'b000 : m_ovf) | ovf_n;
        m_udf = (bus.err_clr ? 3'b000 : m_udf) | udf_n;
        m_bad = (bus.err_clr ? 1'b0 : m_bad) | bad_n;
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write   = 1'b0;
        bus.read    = '0;
        bus.err_clr = 1'b0;
        bus.din     = '0;
    endtask

    task automatic wr(input int tag, input int v);
        bus.write = 1'b1;
        bus.din   = {tag[1:0], v[7:0]};
        tick();
        bus.write = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #1;
        chk("rst_empty", 32'(bus.empty), 32'h7);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_af", 32'(bus.almost_full), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_dv", 32'(bus.dout_valid), 32'h0);
        chk("rst_ovf", 32'(bus.overflow), 32'h0);
        chk("rst_udf", 32'(bus.underflow), 32'h0);
        chk("rst_bad", 32'(bus.bad_tag), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp_d [4];

    initial begin
        compares = 0;
        fails    = 0;
        rst      = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        tick();
        tick();
        chk("t1_empty", 32'(bus.empty), 32'h7);
        chk("t1_dv", 32'(bus.dout_valid), 32'h0);
        chk("t1_dout", 32'(bus.dout), 32'h0);

        wr(1, 'h11);
        wr(1, 'h22);
        chk("t2_af_lo", 32'(bus.almost_full), 32'h0);
        wr(1, 'h33);
        chk("t2_af_hi", 32'(bus.almost_full), 32'h2);
        wr(1, 'h44);
        chk("t2_full", 32'(bus.full), 32'h2);
        chk("t2_cnt1", 32'(bus.count[5:3]), 32'd4);
        wr(1, 'h55);
        chk("t2_ovf", 32'(bus.overflow), 32'h2);
        chk("t2_cnt1b", 32'(bus.count[5:3]), 32'd4);
        chk("t2_model_q1", 32'(mq[1].size()), 32'd4);
        exp_d[0] = 10'h111; exp_d[1] = 10'h122;
        exp_d[2] = 10'h133; exp_d[3] = 10'h144;
        bus.read = 3'b010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_drain", 32'(bus.dout), 32'(exp_d[k]));
            chk("t2_drain_dv", 32'(bus.dout_valid), 32'h1);
        end
        bus.read = '0;
        tick();
        chk("t2_idle_dv", 32'(bus.dout_valid), 32'h0);
        chk("t2_hold", 32'(bus.dout), 32'h144);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("t2_clr", 32'(bus.overflow), 32'h0);

        wr(0, 'hA0);
        wr(1, 'hB0);
        wr(0, 'hA1);
        wr(1, 'hB1);
        exp_d[0] = 10'h0A0; exp_d[1] = 10'h1B0;
        exp_d[2] = 10'h0A1; exp_d[3] = 10'h1B1;
        bus.read = 3'b011;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_rr", 32'(bus.dout), 32'(exp_d[k]));
        end
        bus.read = '0;
        tick();
        chk("t3_empty", 32'(bus.empty), 32'h7);

        bus.read = 3'b001;
        tick();
        bus.read = '0;
        chk("t4_udf", 32'(bus.underflow), 32'h1);
        chk("t4_dv", 32'(bus.dout_valid), 32'h0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("t4_clr", 32'(bus.underflow), 32'h0);

        for (int k = 1; k <= 4; k++) wr(0, k);
        bus.write = 1'b1;
        bus.din   = {2'b00, 8'h99};
        bus.read  = 3'b001;
        tick();
        idle();
        chk("t5_ovf", 32'(bus.overflow), 32'h1);
        chk("t5_cnt0", 32'(bus.count[2:0]), 32'd3);
        chk("t5_dout", 32'(bus.dout), 32'h001);
        chk("t5_dv", 32'(bus.dout_valid), 32'h1);

        wr(3, 'h77);
        chk("t6_bad", 32'(bus.bad_tag), 32'h1);
        chk("t6_cnt", 32'(bus.count), 32'h003);
        wr(2, 'h01);
        wr(2, 'h02);
        do_reset();
        tick();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                bus.write   = ($urandom_range(0, 9) < 7);
                bus.din     = 10'($urandom);
                bus.read    = 3'($urandom);
                bus.err_clr = ($urandom_range(0, 19) == 0);
                tick();
            end
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compares, fails);
        $finish;
    end
endmodule
